mem_wb_stage_reg: RTL
=====================

// Module: mem_wb_stage_reg
// PURPOSE
//  Parametrised MEM/WB pipeline register for the pipelined MIPS core. Captures MEM-stage control and
//  data on clk; adds stall hold, flush-to-bubble, a valid bit, load byte/half alignment and a retire counter.
//  Drives the single WB result and the register-file write strobe. Sits after data memory; feeds the regfile
//  and the hazard/forwarding unit.
// PARAMETERS
//  DATA_W   32  datapath width; multiple of 16, >= 32
//  REGA_W    5  register-file address width
//  CNT_W    32  retire counter width
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  StallW       in   1       hold all W-stage registers
//  FlushW       in   1       load a bubble; has priority over StallW
//  ValidM       in   1       MEM stage holds a real instruction
//  RegWriteM    in   1       instruction writes the register file
//  MemtoRegM    in   1       1 = result from memory, 0 = ALU
//  LoadSizeM    in   2       load size (package encoding): WORD, HALF, BYTE
//  LoadSignedM  in   1       sign-extend sub-word loads
//  ALUResultM   in   DATA_W  ALU result; [1:0] is the byte offset for loads
//  DMReadDataM  in   DATA_W  raw data-memory word
//  WriteRegM    in   REGA_W  destination register
//  ValidW       out  1       W stage holds a real instruction
//  RegWriteW    out  1       qualified regfile write enable
//  WriteRegW    out  REGA_W  destination register
//  ResultW      out  DATA_W  write-back data (also the forwarding source)
//  RetireCnt    out  CNT_W   retired-instruction count
// BEHAVIOUR
//  - Reset (rst_n=0, async): all W registers, including RetireCnt, clear to 0. ValidW=0, RegWriteW=0,
//    ResultW=0. Release is synchronous to the next clk edge.
//  - Latency is 1 cycle, M -> W. No combinational path from any *M input to any output.
//  - Per clk edge, in priority order:
//      FlushW=1          : ValidW<=0, RegWrite reg<=0; data regs are don't-care (the bench checks 0)
//      StallW=1          : every W register holds its value
//      otherwise         : every W register <= its M counterpart
//  - Simultaneous FlushW and StallW: flush wins.
//  - RegWriteW = ValidW & RegWrite reg & (WriteRegW != 0). $0 is never written.
//  - ResultW is combinational from W registers only:
//      MemtoRegW=0 : ALUResultW
//      MemtoRegW=1 : aligned load. off = ALUResultW[1:0], little-endian lanes.
//        WORD : DMReadDataW
//        HALF : lane DMReadDataW[16*off[1] +: 16], zero- or sign-extended to DATA_W
//        BYTE : lane DMReadDataW[8*off +: 8], zero- or sign-extended to DATA_W
//        reserved size encoding: treated as WORD
//  - Misaligned HALF with off[0]=1: off[0] is ignored (the exception is raised upstream).
//  - RetireCnt increments by 1 on each edge with ValidW=1, StallW=0 and no reset. This counts a FlushW
//    edge when the outgoing W instruction is valid, because that instruction has already completed.
//    RetireCnt wraps from 2^CNT_W-1 to 0.
//  - ValidM=0 enters as a bubble: ValidW=0, so RegWriteW=0 whatever RegWriteM is.
// STRUCTURE
//  - Package mips_pipe_pkg: LoadSizeM encodings (LS_WORD=2'b00, LS_HALF=2'b01, LS_BYTE=2'b10);
//    default DATA_W and REGA_W constants.
//  - Sub-module wb_load_align: purely combinational (data, off, size, signed) -> aligned word.
//    It is reused later by the cache refill path.
//  - Top level: one always_ff for the W register bank, one for RetireCnt, and a result mux.
// TESTING
//  1. Reset mid-operation: rst_n low for one half-cycle while ValidW=1 -> ValidW, RegWriteW, ResultW and
//     RetireCnt read 0 immediately, before any clk edge.
//  2. Pass-through: ALU op, RegWriteM=1, WriteRegM=5, ALUResultM=32'h1234_5678 -> the next cycle gives
//     RegWriteW=1, WriteRegW=5, ResultW=32'h1234_5678, and RetireCnt +1 one edge later.
//  3. Byte/half loads: DMReadDataM=32'h80FF_7F01
//       BYTE signed,   off=1         -> 32'h0000_007F
//       BYTE signed,   off=2         -> 32'hFFFF_FFFF
//       HALF unsigned, off=2         -> 32'h0000_80FF
//       HALF signed,   off=2         -> 32'hFFFF_80FF
//  4. Stall then flush: hold StallW=1 for 3 cycles -> outputs are frozen and RetireCnt is unchanged.
//     Then assert FlushW=1 with StallW=1 -> the next cycle gives ValidW=0 and RegWriteW=0.
//  5. $0 suppression: RegWriteM=1, WriteRegM=0 -> RegWriteW=0, ValidW=1, RetireCnt still increments.
//  6. Wrap: CNT_W=4, 17 back-to-back valid instructions -> RetireCnt goes 15 -> 0 -> 1.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mips_pipe_pkg
// Shared constants for the pipelined MIPS core write-back path.
//   LS_*          : load-size encodings carried on LoadSizeM / LoadSizeW
//   DATA_W_DEF    : default datapath width
//   REGA_W_DEF    : default register-file address width
// ---------------------------------------------------------------------------
package mips_pipe_pkg;

    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;

    localparam int DATA_W_DEF = 32;
    localparam int REGA_W_DEF = 5;

endpackage : mips_pipe_pkg

// File: rtl/mem_wb_stage_reg_align.sv
// ---------------------------------------------------------------------------
// wb_load_align
// Purely combinational load aligner: selects the addressed byte/half lane of a
// raw little-endian memory word and zero- or sign-extends it.
//   data_i   in  DATA_W  raw memory word
//   off_i    in  2       byte offset within the word
//   size_i   in  2       load size (LS_WORD / LS_HALF / LS_BYTE)
//   signed_i in  1       sign-extend sub-word loads
//   data_o   out DATA_W  aligned, extended result
// ---------------------------------------------------------------------------
module wb_load_align
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        off_i,
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    output logic [DATA_W-1:0] data_o
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;
    logic        half_sign_s;
    logic        byte_sign_s;

    // Lane selection and extension; off_i[0] is ignored for halfwords
    always_comb begin
        half_s      = data_i[{off_i[1], 4'b0000} +: 16];
        byte_s      = data_i[{off_i, 3'b000} +: 8];
        half_sign_s = signed_i & half_s[15];
        byte_sign_s = signed_i & byte_s[7];
        case (size_i)
            LS_HALF: data_o = {{(DATA_W-16){half_sign_s}}, half_s};
            LS_BYTE: data_o = {{(DATA_W-8){byte_sign_s}}, byte_s};
            // LS_WORD and the reserved encoding both pass the word through
            default: data_o = data_i;
        endcase
    end

endmodule : wb_load_align

// File: rtl/mem_wb_stage_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_reg
// MEM/WB pipeline register: one-cycle capture of MEM-stage control and data
// with stall hold, flush-to-bubble, valid tracking, load alignment and a
// retired-instruction counter.
//   clk, rst_n          clock, asynchronous active-low reset
//   StallW, FlushW      hold / bubble controls (flush wins)
//   ValidM .. WriteRegM MEM-stage control and data
//   ValidW              W stage holds a real instruction
//   RegWriteW           qualified register-file write enable ($0 never written)
//   WriteRegW           destination register
//   ResultW             write-back data, decoded from W registers only
//   RetireCnt           retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module mem_wb_stage_reg
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REGA_W = REGA_W_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              StallW,
    input  logic              FlushW,
    input  logic              ValidM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic [1:0]        LoadSizeM,
    input  logic              LoadSignedM,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] DMReadDataM,
    input  logic [REGA_W-1:0] WriteRegM,
    output logic              ValidW,
    output logic              RegWriteW,
    output logic [REGA_W-1:0] WriteRegW,
    output logic [DATA_W-1:0] ResultW,
    output logic [CNT_W-1:0]  RetireCnt
);

    logic              valid_q,      valid_d;
    logic              regwrite_q,   regwrite_d;
    logic              memtoreg_q,   memtoreg_d;
    logic [1:0]        loadsize_q,   loadsize_d;
    logic              loadsigned_q, loadsigned_d;
    logic [DATA_W-1:0] aluresult_q,  aluresult_d;
    logic [DATA_W-1:0] dmread_q,     dmread_d;
    logic [REGA_W-1:0] writereg_q,   writereg_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
    logic [DATA_W-1:0] load_data_s;

    // Next-state for the W register bank: flush > stall > capture
    always_comb begin
        if (FlushW) begin
            // Data fields are cleared too so a bubble is fully deterministic
            valid_d      = 1'b0;
            regwrite_d   = 1'b0;
            memtoreg_d   = 1'b0;
            loadsize_d   = LS_WORD;
            loadsigned_d = 1'b0;
            aluresult_d  = '0;
            dmread_d     = '0;
            writereg_d   = '0;
        end else if (StallW) begin
            valid_d      = valid_q;
            regwrite_d   = regwrite_q;
            memtoreg_d   = memtoreg_q;
            loadsize_d   = loadsize_q;
            loadsigned_d = loadsigned_q;
            aluresult_d  = aluresult_q;
            dmread_d     = dmread_q;
            writereg_d   = writereg_q;
        end else begin
            valid_d      = ValidM;
            regwrite_d   = RegWriteM;
            memtoreg_d   = MemtoRegM;
            loadsize_d   = LoadSizeM;
            loadsigned_d = LoadSignedM;
            aluresult_d  = ALUResultM;
            dmread_d     = DMReadDataM;
            writereg_d   = WriteRegM;
        end
    end

    // Retire count: the outgoing W instruction completes on any unstalled
    // edge, including a flush edge, since flush only kills the incoming slot
    always_comb begin
        if (valid_q && !StallW) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end else begin
            retire_cnt_d = retire_cnt_q;
        end
    end

    // W register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            loadsize_q   <= LS_WORD;
            loadsigned_q <= 1'b0;
            aluresult_q  <= '0;
            dmread_q     <= '0;
            writereg_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            regwrite_q   <= regwrite_d;
            memtoreg_q   <= memtoreg_d;
            loadsize_q   <= loadsize_d;
            loadsigned_q <= loadsigned_d;
            aluresult_q  <= aluresult_d;
            dmread_q     <= dmread_d;
            writereg_q   <= writereg_d;
        end
    end

    // Retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    wb_load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .data_i   (dmread_q),
        .off_i    (aluresult_q[1:0]),
        .size_i   (loadsize_q),
        .signed_i (loadsigned_q),
        .data_o   (load_data_s)
    );

    // Output decode from W registers only (no path from *M inputs)
    always_comb begin
        ValidW    = valid_q;
        RegWriteW = valid_q & regwrite_q & (writereg_q != '0);
        WriteRegW = writereg_q;
        RetireCnt = retire_cnt_q;
        if (memtoreg_q) begin
            ResultW = load_data_s;
        end else begin
            ResultW = aluresult_q;
        end
    end

endmodule : mem_wb_stage_reg
